rvga_cword_queue: RTL and testbench

- Parametrised, ready/valid decoupling queue for pipeline control words between any two rvga stages, e.g. execute→memory or memory→writeback.
- Generalises the fixed one-deep stage register: configurable payload width, depth and number of forwarding lookup ports.
- Adds a synchronous flush.
- Adds a youngest-match register-forwarding search over all resident entries, so downstream hazard logic can bypass from queued instructions.

---
 rtl/rvga_types.sv | 20 ++
 rtl/rvga_fwd_match.sv | 46 ++++
 rtl/rvga_cword_queue.sv | 123 ++++++++++++
 tb/tb_rvga_cword_queue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvga_types.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rvga_types : shared rvga register/word types and forwarding entry      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package rvga_types;

  typedef logic [4:0]  rvga_reg;
  typedef logic [31:0] rvga_word;

  typedef struct packed {
    logic     v;
    rvga_reg  rd;
    logic     rd_w_v;
    logic     rd_data_v;
    rvga_word rd_data;
  } rvga_fwd_entry;

endpackage
`default_nettype wire

// File: rtl/rvga_fwd_match.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rvga_fwd_match : youngest-match forwarding search over queue entries   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module rvga_fwd_match
  import rvga_types::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  rvga_fwd_entry    entries_i [DEPTH],
  input  logic [PTR_W-1:0] rd_ptr_i,
  input  rvga_reg          rs_i,
  output logic             hit_o,
  output logic             data_v_o,
  output rvga_word         data_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; a later match overwrites, so the youngest wins.
  always_comb begin
    hit_o    = 1'b0;
    data_v_o = 1'b0;
    data_o   = '0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = {1'b0, rd_ptr_i} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(DEPTH)) begin
        sum = sum - (PTR_W+1)'(DEPTH);
      end
      idx = sum[PTR_W-1:0];
      if (entries_i[idx].v && entries_i[idx].rd_w_v &&
          (entries_i[idx].rd == rs_i) && (rs_i != '0)) begin
        hit_o    = 1'b1;
        data_v_o = entries_i[idx].rd_data_v;
        data_o   = entries_i[idx].rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rvga_cword_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rvga_cword_queue : ready/valid control-word queue with flush and       |
// |                    youngest-match register forwarding lookups          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module rvga_cword_queue
  import rvga_types::*;
#(
  parameter int  WIDTH   = 256,
  parameter int  DEPTH   = 4,
  parameter int  NUM_LKP = 2,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 enq_v_i,
  output logic                 enq_ready_o,
  input  logic [WIDTH-1:0]     enq_cword_i,
  input  logic [4:0]           enq_rd_i,
  input  logic                 enq_rd_w_v_i,
  input  logic                 enq_rd_data_v_i,
  input  logic [31:0]          enq_rd_data_i,
  output logic                 deq_v_o,
  input  logic                 deq_ready_i,
  output logic [WIDTH-1:0]     deq_cword_o,
  output logic [31:0]          deq_rd_data_o,
  output logic [CNT_W-1:0]     count_o,
  input  logic [NUM_LKP*5-1:0] lkp_rs_i,
  output logic [NUM_LKP-1:0]   lkp_hit_o,
  output logic [NUM_LKP-1:0]   lkp_data_v_o,
  output logic [NUM_LKP*32-1:0] lkp_data_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  rvga_fwd_entry    entries_q [DEPTH];
  rvga_fwd_entry    entries_d [DEPTH];
  logic [WIDTH-1:0] payload_q [DEPTH];
  logic [WIDTH-1:0] payload_d [DEPTH];

  logic enq_fire;
  logic deq_fire;

  assign deq_v_o     = (count_q != '0);
  assign enq_ready_o = (count_q != CNT_W'(DEPTH));
  assign count_o     = count_q;
  assign enq_fire    = enq_v_i & enq_ready_o;
  assign deq_fire    = deq_v_o & deq_ready_i;

  assign deq_cword_o   = deq_v_o ? payload_q[rd_ptr_q] : '0;
  assign deq_rd_data_o = deq_v_o ? entries_q[rd_ptr_q].rd_data : '0;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    entries_d = entries_q;
    payload_d = payload_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].v = 1'b0;
      end
    end else begin
      // When both fire the queue is neither empty nor full, so wr_ptr != rd_ptr.
      if (enq_fire) begin
        entries_d[wr_ptr_q] = '{v: 1'b1, rd: enq_rd_i, rd_w_v: enq_rd_w_v_i,
                                rd_data_v: enq_rd_data_v_i, rd_data: enq_rd_data_i};
        payload_d[wr_ptr_q] = enq_cword_i;
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        entries_d[rd_ptr_q].v = 1'b0;
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (enq_fire && !deq_fire) begin
        count_d = count_q + CNT_W'(1);
      end else if (!enq_fire && deq_fire) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      entries_q <= '{default: '0};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  // Payload is only observed behind a valid entry, so it needs no reset.
  always_ff @(posedge clk_i) begin
    payload_q <= payload_d;
  end

  for (genvar k = 0; k < NUM_LKP; k++) begin : g_lkp
    rvga_fwd_match #(
      .DEPTH (DEPTH)
    ) u_match (
      .entries_i (entries_q),
      .rd_ptr_i  (rd_ptr_q),
      .rs_i      (lkp_rs_i[5*k +: 5]),
      .hit_o     (lkp_hit_o[k]),
      .data_v_o  (lkp_data_v_o[k]),
      .data_o    (lkp_data_o[32*k +: 32])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_rvga_cword_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_rvga_cword_queue : directed + random bench, DEPTH=4 and DEPTH=3     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_rvga_cword_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_v;
  logic [15:0] enq_cword;
  logic [4:0]  enq_rd;
  logic        enq_wv;
  logic        enq_dv;
  logic [31:0] enq_data;
  logic        deq_ready;
  logic [9:0]  lkp_rs;

  logic        ready_a, deq_v_a, ready_b, deq_v_b;
  logic [15:0] cword_a, cword_b;
  logic [31:0] rdd_a, rdd_b;
  logic [2:0]  count_a;
  logic [1:0]  count_b;
  logic [1:0]  hit_a, ldv_a, hit_b, ldv_b;
  logic [63:0] ldata_a, ldata_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] cw;
    logic [4:0]  rd;
    logic        wv;
    logic        dv;
    logic [31:0] data;
  } ment_t;

  ment_t mq[2][$];

  always #5 clk = ~clk;

  rvga_cword_queue #(.WIDTH(16), .DEPTH(4), .NUM_LKP(2)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .flush_i(flush),
    .enq_v_i(enq_v), .enq_ready_o(ready_a), .enq_cword_i(enq_cword),
    .enq_rd_i(enq_rd), .enq_rd_w_v_i(enq_wv), .enq_rd_data_v_i(enq_dv),
    .enq_rd_data_i(enq_data), .deq_v_o(deq_v_a), .deq_ready_i(deq_ready),
    .deq_cword_o(cword_a), .deq_rd_data_o(rdd_a), .count_o(count_a),
    .lkp_rs_i(lkp_rs), .lkp_hit_o(hit_a), .lkp_data_v_o(ldv_a), .lkp_data_o(ldata_a)
  );

  rvga_cword_queue #(.WIDTH(16), .DEPTH(3), .NUM_LKP(2)) u_dut3 (
    .clk_i(clk), .reset_i(rst), .flush_i(flush),
    .enq_v_i(enq_v), .enq_ready_o(ready_b), .enq_cword_i(enq_cword),
    .enq_rd_i(enq_rd), .enq_rd_w_v_i(enq_wv), .enq_rd_data_v_i(enq_dv),
    .enq_rd_data_i(enq_data), .deq_v_o(deq_v_b), .deq_ready_i(deq_ready),
    .deq_cword_o(cword_b), .deq_rd_data_o(rdd_b), .count_o(count_b),
    .lkp_rs_i(lkp_rs), .lkp_hit_o(hit_b), .lkp_data_v_o(ldv_b), .lkp_data_o(ldata_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int m, input string nm, input logic ready,
                            input logic dv, input logic [15:0] cw, input logic [31:0] rdd,
                            input logic [2:0] cnt, input logic [1:0] hit,
                            input logic [1:0] ldv, input logic [63:0] ldata);
    int d;
    int sz;
    logic [4:0]  rs;
    logic        eh, edv;
    logic [31:0] ed;
    d  = (m == 0) ? 4 : 3;
    sz = mq[m].size();
    chk({nm, "_deq_v"}, 64'(dv), 64'(sz != 0));
    chk({nm, "_enq_ready"}, 64'(ready), 64'(sz != d));
    chk({nm, "_count"}, 64'(cnt), 64'(sz));
    if (sz != 0) begin
      chk({nm, "_deq_cword"}, 64'(cw), 64'(mq[m][0].cw));
      chk({nm, "_deq_rd_data"}, 64'(rdd), 64'(mq[m][0].data));
    end
    for (int k = 0; k < 2; k++) begin
      rs  = lkp_rs[5*k +: 5];
      eh  = 1'b0;
      edv = 1'b0;
      ed  = '0;
      for (int i = sz - 1; i >= 0; i--) begin
        if (rs != 5'd0 && mq[m][i].wv && mq[m][i].rd == rs) begin
          eh  = 1'b1;
          edv = mq[m][i].dv;
          ed  = mq[m][i].data;
          break;
        end
      end
      chk($sformatf("%s_lkp%0d_hit", nm, k), 64'(hit[k]), 64'(eh));
      chk($sformatf("%s_lkp%0d_data_v", nm, k), 64'(ldv[k]), 64'(edv));
      chk($sformatf("%s_lkp%0d_data", nm, k), 64'(ldata[32*k +: 32]), 64'(ed));
    end
  endtask

  task automatic check_all();
    check_inst(0, "d4", ready_a, deq_v_a, cword_a, rdd_a, count_a, hit_a, ldv_a, ldata_a);
    check_inst(1, "d3", ready_b, deq_v_b, cword_b, rdd_b, {1'b0, count_b}, hit_b, ldv_b, ldata_b);
  endtask

  task automatic model_update();
    ment_t e;
    int    d, sz;
    bit    ef, df;
    e = '{cw: enq_cword, rd: enq_rd, wv: enq_wv, dv: enq_dv, data: enq_data};
    for (int m = 0; m < 2; m++) begin
      d  = (m == 0) ? 4 : 3;
      sz = mq[m].size();
      ef = enq_v && (sz != d);
      df = (sz != 0) && deq_ready;
      if (rst || flush) begin
        mq[m].delete();
      end else begin
        if (df) void'(mq[m].pop_front());
        if (ef) mq[m].push_back(e);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [15:0] cw, input logic [4:0] rd,
                         input logic wv, input logic dv, input logic [31:0] data);
    enq_v = v; enq_cword = cw; enq_rd = rd; enq_wv = wv; enq_dv = dv; enq_data = data;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; deq_ready = 1'b0; lkp_rs = '0;
    set_enq(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("reset_deq_v", 64'(deq_v_a), 64'd0);
    chk("reset_enq_ready", 64'(ready_a), 64'd1);
    rst = 1'b0;

    // Fill and drain.
    for (int i = 1; i <= 5; i++) begin
      set_enq(1, 16'(i), 5'd1, 1, 1, 32'(i));
      cycle();
    end
    chk("fill_count", 64'(count_a), 64'd4);
    chk("fill_ready", 64'(ready_a), 64'd0);
    cycle();
    chk("fill_held_count", 64'(count_a), 64'd4);
    enq_v = 1'b0;
    deq_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 64'(cword_a), 64'(i));
      cycle();
    end
    chk("drain_count", 64'(count_a), 64'd0);

    // Wrap with simultaneous enqueue/dequeue on DEPTH=3.
    deq_ready = 1'b0;
    set_enq(1, 16'd100, 5'd2, 1, 1, 32'd100);
    cycle();
    for (int i = 1; i <= 10; i++) begin
      set_enq(1, 16'(100 + i), 5'd2, 1, 1, 32'(100 + i));
      deq_ready = 1'b1;
      chk("wrap_count", 64'(count_b), 64'd1);
      chk("wrap_order", 64'(cword_b), 64'(100 + i - 1));
      cycle();
    end
    enq_v = 1'b0;
    cycle();
    chk("wrap_empty", 64'(count_b), 64'd0);

    // Youngest match: a pending younger entry shadows an older final one.
    deq_ready = 1'b0;
    set_enq(1, 16'h1, 5'd5, 1, 1, 32'h11);
    cycle();
    set_enq(1, 16'h2, 5'd5, 1, 0, 32'h22);
    cycle();
    enq_v = 1'b0;
    lkp_rs = {5'd5, 5'd5};
    #1;
    chk("young_hit", 64'(hit_a[0]), 64'd1);
    chk("young_data_v", 64'(ldv_a[0]), 64'd0);
    chk("young_data", 64'(ldata_a[31:0]), 64'h22);
    deq_ready = 1'b1;
    cycle();
    chk("young_after_a_hit", 64'(hit_a[1]), 64'd1);
    chk("young_after_a_data_v", 64'(ldv_a[1]), 64'd0);
    cycle();
    chk("young_after_b_hit", 64'(hit_a), 64'd0);
    chk("young_after_b_data", 64'(ldata_a), 64'd0);

    // x0 and non-writing entries never hit.
    deq_ready = 1'b0;
    set_enq(1, 16'h3, 5'd0, 1, 1, 32'h33);
    cycle();
    set_enq(1, 16'h4, 5'd7, 0, 1, 32'h44);
    cycle();
    enq_v = 1'b0;
    lkp_rs = {5'd7, 5'd0};
    cycle();
    chk("x0_nowrite_hit", 64'(hit_a), 64'd0);
    deq_ready = 1'b1;
    cycle();
    cycle();
    deq_ready = 1'b0;

    // Flush with a concurrent enqueue.
    for (int i = 0; i < 3; i++) begin
      set_enq(1, 16'(20 + i), 5'd9, 1, 1, 32'(i));
      cycle();
    end
    lkp_rs = {5'd9, 5'd9};
    #1;
    chk("preflush_count", 64'(count_a), 64'd3);
    chk("preflush_hit", 64'(hit_a), 64'd3);
    flush = 1'b1;
    set_enq(1, 16'h99, 5'd9, 1, 1, 32'h99);
    cycle();
    flush = 1'b0;
    enq_v = 1'b0;
    chk("flush_count", 64'(count_a), 64'd0);
    chk("flush_deq_v", 64'(deq_v_a), 64'd0);
    chk("flush_hit", 64'(hit_a), 64'd0);
    cycle();
    chk("flush_enq_lost", 64'(count_b), 64'd0);

    // Asynchronous reset between edges.
    set_enq(1, 16'h51, 5'd3, 1, 1, 32'h51);
    cycle();
    set_enq(1, 16'h52, 5'd3, 1, 1, 32'h52);
    cycle();
    enq_v = 1'b0;
    chk("prereset_count", 64'(count_a), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_deq_v", 64'(deq_v_a), 64'd0);
    chk("async_rst_enq_ready", 64'(ready_a), 64'd1);
    chk("async_rst_deq_v_d3", 64'(deq_v_b), 64'd0);
    mq[0].delete();
    mq[1].delete();
    cycle();
    rst = 1'b0;
    set_enq(1, 16'hBEEF, 5'd4, 1, 1, 32'hBEEF);
    cycle();
    enq_v = 1'b0;
    chk("post_rst_deq_v", 64'(deq_v_a), 64'd1);
    chk("post_rst_cword", 64'(cword_a), 64'hBEEF);

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      set_enq(($urandom % 3) != 0, 16'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), $urandom);
      deq_ready = 1'($urandom);
      lkp_rs    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      flush     = (($urandom % 40) == 0);
      cycle();
    end
    flush = 1'b0;
    enq_v = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
